perf_event_counter_bank: RTL

//  Parametrised successor to the performance event counter block. One counter per event channel.

---
 rtl/perf_event_counter_bank_if.sv | 39 +++
 rtl/perf_event_counter_bank.sv | 129 ++++++++++++
 2 files changed

// File: rtl/perf_event_counter_bank_if.sv
// Snapshot request/accept and the drain stream of perf_event_counter_bank.
// The master side is the counter bank; the slave side is the monitoring pipeline.
interface perf_event_counter_bank_if #(
   parameter int N_EVENTS      = 115,
   parameter int COUNTER_WIDTH = 7
);
   localparam int IDX_WIDTH = $clog2(N_EVENTS);

   logic                     snapshot;
   logic                     snapshot_ready;
   logic                     drain_valid;
   logic                     drain_ready;
   logic [IDX_WIDTH-1:0]     drain_index;
   logic [COUNTER_WIDTH-1:0] drain_data;
   logic                     drain_overflow;
   logic                     drain_last;

   modport master (
      input  snapshot,
      input  drain_ready,
      output snapshot_ready,
      output drain_valid,
      output drain_index,
      output drain_data,
      output drain_overflow,
      output drain_last
   );

   modport slave (
      output snapshot,
      output drain_ready,
      input  snapshot_ready,
      input  drain_valid,
      input  drain_index,
      input  drain_data,
      input  drain_overflow,
      input  drain_last
   );
endinterface

// File: rtl/perf_event_counter_bank.sv
// Per-channel event counters with atomic snapshot; 1-cycle count latency, first drain beat 1 cycle after capture.
// Drain stream stalls in place on !drain_ready; snapshot requests are refused while a drain is in progress.
module perf_event_counter_bank #(
   parameter int N_EVENTS      = 115,
   parameter int COUNTER_WIDTH = 7
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N_EVENTS-1:0]               performance_events,
   input  logic [N_EVENTS-1:0]               event_enable,
   input  logic                              saturate,
   output logic [N_EVENTS*COUNTER_WIDTH-1:0] counters,
   output logic [N_EVENTS-1:0]               overflow,
   perf_event_counter_bank_if.master         drain_if
);
   localparam int IDX_WIDTH = $clog2(N_EVENTS);
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
   localparam logic [IDX_WIDTH-1:0]     IDX_ONE  = IDX_WIDTH'(1);
   localparam logic [IDX_WIDTH-1:0]     LAST_IDX = IDX_WIDTH'(N_EVENTS - 1);

   typedef enum logic {ST_IDLE, ST_DRAIN} state_e;

   logic [N_EVENTS-1:0][COUNTER_WIDTH-1:0] cnt_q, cnt_d;
   logic [N_EVENTS-1:0][COUNTER_WIDTH-1:0] snap_cnt_q, snap_cnt_d;
   logic [N_EVENTS-1:0]                    ovf_q, ovf_d;
   logic [N_EVENTS-1:0]                    snap_ovf_q, snap_ovf_d;
   logic [N_EVENTS-1:0]                    hit;

   state_e               state_q, state_d;
   logic [IDX_WIDTH-1:0] idx_q, idx_d;
   logic                 valid_q, valid_d;
   logic                 ready_q, ready_d;
   logic                 last_q, last_d;
   logic                 snap_acc;
   logic                 xfer;

   assign hit = performance_events & event_enable;
   // ready_q resets to 1, so gating with rst keeps the output low only while reset is held
   assign drain_if.snapshot_ready = ready_q & ~rst;
   assign snap_acc = drain_if.snapshot & drain_if.snapshot_ready;
   assign xfer     = valid_q & drain_if.drain_ready;

   always_comb begin
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      snap_cnt_d = snap_cnt_q;
      snap_ovf_d = snap_ovf_q;
      if (snap_acc) begin
         snap_cnt_d = cnt_q;
         snap_ovf_d = ovf_q;
         ovf_d      = '0;
         // an event in the capture cycle starts the new window rather than being dropped
         for (int i = 0; i < N_EVENTS; i++) begin
            cnt_d[i] = hit[i] ? CNT_ONE : '0;
         end
      end else begin
         for (int i = 0; i < N_EVENTS; i++) begin
            if (hit[i]) begin
               if (cnt_q[i] == CNT_MAX) begin
                  ovf_d[i] = 1'b1;
                  cnt_d[i] = saturate ? CNT_MAX : '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (snap_acc) begin
               state_d = ST_DRAIN;
               idx_d   = '0;
            end
         end
         ST_DRAIN: begin
            if (xfer) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      valid_d = (state_d == ST_DRAIN);
      ready_d = (state_d == ST_IDLE);
      last_d  = valid_d && (idx_d == LAST_IDX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         ovf_q      <= '0;
         snap_cnt_q <= '0;
         snap_ovf_q <= '0;
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         valid_q    <= 1'b0;
         ready_q    <= 1'b1;
         last_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         snap_cnt_q <= snap_cnt_d;
         snap_ovf_q <= snap_ovf_d;
         state_q    <= state_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
         ready_q    <= ready_d;
         last_q     <= last_d;
      end
   end

   assign counters                = cnt_q;
   assign overflow                = ovf_q;
   assign drain_if.drain_valid    = valid_q;
   assign drain_if.drain_index    = idx_q;
   assign drain_if.drain_data     = snap_cnt_q[idx_q];
   assign drain_if.drain_overflow = snap_ovf_q[idx_q];
   assign drain_if.drain_last     = last_q;
endmodule
